// File: rtl/simd_sat_alu_pipe_if.sv
// Operand/result handshake bundle for the SIMD saturating add/sub pipeline.
interface simd_sat_alu_pipe_if #(
  parameter int DW = 64
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [1:0]    width;
  logic          sub;
  logic [1:0]    sat_mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] c;
  logic [DW/8-1:0] ovf;
  logic [DW/8-1:0] ovf_sticky;
  logic          clr_sticky;

  modport master (
    output in_valid, a, b, width, sub, sat_mode, out_ready, clr_sticky,
    input  in_ready, out_valid, c, ovf, ovf_sticky
  );

  modport slave (
    input  in_valid, a, b, width, sub, sat_mode, out_ready, clr_sticky,
    output in_ready, out_valid, c, ovf, ovf_sticky
  );
endinterface

// File: rtl/simd_sat_alu_pipe.sv
// Two-stage SIMD add/sub with per-lane wrap or signed/unsigned saturation.
// Lanes are built from byte slices whose carry chain is cut at lane starts.
module simd_sat_alu_pipe #(
  parameter int DW = 64
) (
  input logic               clk,
  input logic               rst_n,
  simd_sat_alu_pipe_if.slave bus
);
  localparam int NB = DW / 8;

  logic          vld_p1, vld_p2;
  logic [DW-1:0] a_p1, b_p1;
  logic [1:0]    width_p1, mode_p1;
  logic          sub_p1;
  logic [DW-1:0] c_p2;
  logic [NB-1:0] ovf_p2, sticky;
  logic          s1_en, s2_en, consume;

  logic [DW-1:0] raw, res;
  logic [NB-1:0] top_ovf, top_neg, lane_ovf, lane_neg;

  assign s2_en        = !vld_p2 || bus.out_ready;
  assign s1_en        = !vld_p1 || s2_en;
  assign consume      = vld_p2 && bus.out_ready;
  assign bus.in_ready = s1_en;
  assign bus.out_valid  = vld_p2;
  assign bus.c          = c_p2;
  assign bus.ovf        = ovf_p2;
  assign bus.ovf_sticky = sticky;

  function automatic logic lane_start(input logic [1:0] w, input int i);
    case (w)
      2'b00:   return 1'b1;
      2'b01:   return (i % 2) == 0;
      2'b10:   return (i % 4) == 0;
      default: return i == 0;
    endcase
  endfunction

  function automatic logic lane_top(input logic [1:0] w, input int i);
    case (w)
      2'b00:   return 1'b1;
      2'b01:   return (i % 2) == 1;
      2'b10:   return (i % 4) == 3;
      default: return i == NB - 1;
    endcase
  endfunction

  // Saturated byte for a lane slice; only the top byte carries the sign pattern.
  function automatic logic [7:0] sat_byte(input logic [1:0] mode, input logic top,
                                          input logic a_neg, input logic is_sub);
    if (mode == 2'b01)
      return top ? (a_neg ? 8'h80 : 8'h7F) : (a_neg ? 8'h00 : 8'hFF);
    else
      return is_sub ? 8'h00 : 8'hFF;
  endfunction

  always_comb begin : lane_math
    logic       carry, cin, s_ovf, u_ovf, run_ovf, run_neg, sat_on;
    logic [7:0] bx;
    logic [8:0] sum9;
    raw = '0; res = '0; top_ovf = '0; top_neg = '0; lane_ovf = '0; lane_neg = '0;
    carry = 1'b0; cin = 1'b0; s_ovf = 1'b0; u_ovf = 1'b0;
    run_ovf = 1'b0; run_neg = 1'b0; bx = '0; sum9 = '0;
    sat_on = (mode_p1 == 2'b01) || (mode_p1 == 2'b10);
    for (int i = 0; i < NB; i++) begin
      cin  = lane_start(width_p1, i) ? sub_p1 : carry;
      bx   = b_p1[8*i +: 8] ^ {8{sub_p1}};
      sum9 = {1'b0, a_p1[8*i +: 8]} + {1'b0, bx} + {8'b0, cin};
      raw[8*i +: 8] = sum9[7:0];
      carry = sum9[8];
      s_ovf = (a_p1[8*i+7] == bx[7]) && (sum9[7] != a_p1[8*i+7]);
      u_ovf = sum9[8] ^ sub_p1;
      top_ovf[i] = (mode_p1 == 2'b10) ? u_ovf : s_ovf;
      top_neg[i] = a_p1[8*i+7];
    end
    // Spread each lane's top-byte verdict down over the whole lane.
    for (int i = NB - 1; i >= 0; i--) begin
      if (lane_top(width_p1, i)) begin
        run_ovf = top_ovf[i];
        run_neg = top_neg[i];
      end
      lane_ovf[i] = run_ovf;
      lane_neg[i] = run_neg;
      res[8*i +: 8] = (run_ovf && sat_on)
                    ? sat_byte(mode_p1, lane_top(width_p1, i), run_neg, sub_p1)
                    : raw[8*i +: 8];
    end
  end

  // Stage 1: operands and per-beat controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     vld_p1 <= 1'b0;
    else if (s1_en) vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (s1_en && bus.in_valid) begin
      a_p1     <= bus.a;
      b_p1     <= bus.b;
      width_p1 <= bus.width;
      mode_p1  <= bus.sat_mode;
      sub_p1   <= bus.sub;
    end
  end

  // Stage 2: lane results, overflow flags and sticky accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      c_p2   <= '0;
      ovf_p2 <= '0;
    end else if (s2_en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        c_p2   <= res;
        ovf_p2 <= lane_ovf;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              sticky <= '0;
    else if (consume)        sticky <= (bus.clr_sticky ? '0 : sticky) | ovf_p2;
    else if (bus.clr_sticky) sticky <= '0;
  end
endmodule
